// File: rtl/y_demux4_router_if.sv
// Bus bundle for the 1-to-4 router: one producer stream in, four consumer
// lanes out, plus the per-lane delivered-word counters.
interface y_demux4_router_if #(
    parameter int SIZE = 32,
    parameter int CW   = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [SIZE-1:0] z0, z1, z2, z3;
    logic [CW-1:0]   cnt0, cnt1, cnt2, cnt3;

    // Producer and consumers drive this side.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, z0, z1, z2, z3, cnt0, cnt1, cnt2, cnt3
    );

    // The router itself.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, z0, z1, z2, z3, cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/y_demux4_router.sv
// Registered 1-to-4 demultiplexer. Each word from the shared input stream
// lands in a one-entry register on its selected lane; lanes drain on their
// own valid/ready handshake and count the words they deliver.
module y_demux4_router #(
    parameter int SIZE = 32,
    parameter int CW   = 8
) (
    input logic              clk,
    input logic              reset_n,
    y_demux4_router_if.slave bus
);

    logic [3:0]      vld_q;
    logic [SIZE-1:0] z_q   [4];
    logic [CW-1:0]   cnt_q [4];
    logic [3:0]      load;
    logic [3:0]      drain;
    logic            in_ready_c;

    // Accept when the selected lane is empty or is draining this edge, so a
    // full lane with a ready consumer sustains one word per cycle.
    always_comb begin
        in_ready_c = ~vld_q[bus.in_sel] | bus.out_ready[bus.in_sel];
        load       = 4'b0000;
        if (bus.in_valid && in_ready_c) begin
            load[bus.in_sel] = 1'b1;
        end
        drain = vld_q & bus.out_ready;
    end

    // Lane registers, valid bits and delivered-word counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                z_q[i]   <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            vld_q <= load | (vld_q & ~drain);
            for (int i = 0; i < 4; i++) begin
                // z keeps its last value after drain; only a load replaces it.
                if (load[i]) begin
                    z_q[i] <= bus.in_data;
                end
                if (drain[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_q;
    assign bus.z0        = z_q[0];
    assign bus.z1        = z_q[1];
    assign bus.z2        = z_q[2];
    assign bus.z3        = z_q[3];
    assign bus.cnt0      = cnt_q[0];
    assign bus.cnt1      = cnt_q[1];
    assign bus.cnt2      = cnt_q[2];
    assign bus.cnt3      = cnt_q[3];

endmodule

// File: tb/tb_y_demux4_router.sv
// Directed bench for y_demux4_router: reset, routing, backpressure,
// streaming, counter wrap and reset in the middle of traffic.
module tb_y_demux4_router;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    y_demux4_router_if #(.SIZE(32), .CW(8)) bus ();

    y_demux4_router #(.SIZE(32), .CW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
        reset_n = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_out_valid got=%b want=0000", bus.out_valid);
        end
        n_tests++;
        if ({bus.z0, bus.z1, bus.z2, bus.z3} !== 128'h0) begin
            n_fail++; $display("FAIL reset_z got=%h %h %h %h want=0", bus.z0, bus.z1, bus.z2, bus.z3);
        end
        n_tests++;
        if ({bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3} !== 32'h0) begin
            n_fail++; $display("FAIL reset_cnt got=%h %h %h %h want=0", bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3);
        end
        tick();
        reset_n = 1'b1;
        bus.in_sel = 2'd2;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready);
        end
        // Ready on empty lanes must not count anything.
        bus.out_ready = 4'b1111;
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if ({bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3} !== 32'h0 || bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL ready_on_empty got=%h %h %h %h v=%b want=0", bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3, bus.out_valid);
        end
    endtask

    task automatic test_basic_route();
        bus.in_data  = 32'hDEADBEEF;
        bus.in_sel   = 2'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 4'b0010) begin
            n_fail++; $display("FAIL basic_valid got=%b want=0010", bus.out_valid);
        end
        n_tests++;
        if (bus.z1 !== 32'hDEADBEEF || bus.z0 !== 32'h0 || bus.z2 !== 32'h0 || bus.z3 !== 32'h0) begin
            n_fail++; $display("FAIL basic_z got=%h %h %h %h want=0 deadbeef 0 0", bus.z0, bus.z1, bus.z2, bus.z3);
        end
        bus.out_ready = 4'b0010;
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if (bus.out_valid !== 4'b0000 || bus.cnt1 !== 8'd1 || bus.z1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL basic_drain got v=%b cnt1=%0d z1=%h want v=0000 cnt1=1 z1=deadbeef", bus.out_valid, bus.cnt1, bus.z1);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.in_data  = 32'h11111111;
        bus.in_sel   = 2'd3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 32'h22222222;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.z3 !== 32'h11111111 || bus.out_valid !== 4'b1000) begin
                n_fail++; $display("FAIL bp_hold[%0d] got rdy=%b z3=%h v=%b want rdy=0 z3=11111111 v=1000", k, bus.in_ready, bus.z3, bus.out_valid);
            end
            tick();
        end
        // Readiness reflects only the selected lane.
        bus.in_sel = 2'd0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_other_lane_ready got=%b want=1", bus.in_ready);
        end
        bus.in_sel    = 2'd3;
        bus.out_ready = 4'b1000;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 4'b1000 || bus.z3 !== 32'h22222222 || bus.cnt3 !== 8'd1) begin
            n_fail++; $display("FAIL bp_swap got v=%b z3=%h cnt3=%0d want v=1000 z3=22222222 cnt3=1", bus.out_valid, bus.z3, bus.cnt3);
        end
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if (bus.out_valid !== 4'b0000 || bus.cnt3 !== 8'd2) begin
            n_fail++; $display("FAIL bp_final got v=%b cnt3=%0d want v=0000 cnt3=2", bus.out_valid, bus.cnt3);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.in_sel   = 2'(i);
            bus.in_data  = 32'(i + 1);
            bus.in_valid = 1'b1;
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d] got=%b want=1", i, bus.in_ready);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if (bus.z0 !== 32'd1 || bus.z1 !== 32'd2 || bus.z2 !== 32'd3 || bus.z3 !== 32'd4) begin
            n_fail++; $display("FAIL stream_z got=%h %h %h %h want=1 2 3 4", bus.z0, bus.z1, bus.z2, bus.z3);
        end
        n_tests++;
        if (bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd1 || bus.cnt2 !== 8'd1 || bus.cnt3 !== 8'd1 || bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL stream_cnt got=%0d %0d %0d %0d v=%b want=1 1 1 1 v=0000", bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3, bus.out_valid);
        end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        bus.out_ready = 4'b0001;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bus.in_data = 32'(k);
            tick();
            n_tests++;
            if ({bus.cnt1, bus.cnt2, bus.cnt3} !== 24'h0) begin
                n_fail++; $display("FAIL wrap_others[%0d] got=%0d %0d %0d want=0", k, bus.cnt1, bus.cnt2, bus.cnt3);
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.cnt0 !== 8'd255 || bus.z0 !== 32'd255 || bus.out_valid !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_pre got cnt0=%0d z0=%0d v=%b want 255 255 0001", bus.cnt0, bus.z0, bus.out_valid);
        end
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if (bus.cnt0 !== 8'd0 || bus.out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_zero got cnt0=%0d v=%b want 0 0000", bus.cnt0, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 32'h100;
        tick();
        bus.in_sel  = 2'd2;
        bus.in_data = 32'h200;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0001;
        tick();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'h300;
        tick();
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 4'b0101 || bus.cnt0 !== 8'd1) begin
            n_fail++; $display("FAIL mid_setup got v=%b cnt0=%0d want v=0101 cnt0=1", bus.out_valid, bus.cnt0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 4'b0000 || {bus.cnt0, bus.cnt1, bus.cnt2, bus.cnt3} !== 32'h0 || bus.z2 !== 32'h0) begin
            n_fail++; $display("FAIL mid_async got v=%b cnt0=%0d z2=%h want 0000 0 0", bus.out_valid, bus.cnt0, bus.z2);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b1111;
        tick();
        n_tests++;
        if (bus.out_valid !== 4'b0000 || bus.z0 !== 32'h0 || bus.cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL mid_held got v=%b z0=%h cnt0=%0d want 0000 0 0", bus.out_valid, bus.z0, bus.cnt0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        reset_n = 1'b1;
        bus.in_sel   = 2'd2;
        bus.in_data  = 32'hA5A5A5A5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0100;
        n_tests++;
        if (bus.out_valid !== 4'b0100 || bus.z2 !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL mid_reload got v=%b z2=%h want 0100 a5a5a5a5", bus.out_valid, bus.z2);
        end
        tick();
        bus.out_ready = 4'b0000;
        n_tests++;
        if (bus.out_valid !== 4'b0000 || bus.cnt2 !== 8'd1 || bus.cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL mid_deliver got v=%b cnt2=%0d cnt0=%0d want 0000 1 0", bus.out_valid, bus.cnt2, bus.cnt0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_route();
        test_backpressure();
        test_streaming();
        test_counter_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
